sid_write_arb: RTL and testbench

SID_WRITE_ARB -- requirements
Module: sid_write_arb

---
 rtl/sid_write_arb.sv | 193 +++++++++++++++++++
 tb/tb_sid_write_arb.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_arb.sv
// sid_write_arb: two-requester arbiter for the shared SID register write bus.
// A granted write waits for a clkEn strobe, then goes out as a single oWE
// pulse in a cycle where clkEn is low. Out-of-range addresses are acknowledged
// but dropped, and oDropCnt counts them.
// Optional feature: define SID_WRITE_SHADOW_EN to add a readable shadow copy
// of every issued register write. Without it, oRdData is tied to zero.
module sid_write_arb #(
  parameter logic [4:0] ADDR_MAX = 5'h18
) (
  input  logic       clk,
  input  logic       iRstN,
  input  logic       clkEn,
  input  logic       iReqA,
  input  logic [4:0] iAddrA,
  input  logic [7:0] iDataA,
  input  logic       iReqB,
  input  logic [4:0] iAddrB,
  input  logic [7:0] iDataB,
  output logic       oAckA,
  output logic       oAckB,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic [7:0] oDropCnt,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdData
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE
  } state_t;

  logic [1:0] r_rstSync;
  logic       w_rstN;

  state_t     r_state;
  state_t     w_stateNxt;

  logic       w_grantA;
  logic       w_grantB;
  logic [4:0] w_selAddr;
  logic [7:0] w_selData;
  logic       w_inRange;
  logic       w_we;

  logic       r_ackA;
  logic       r_ackB;
  logic       r_favB;
  logic [4:0] r_addr;
  logic [7:0] r_data;
  logic [4:0] r_issAddr;
  logic [7:0] r_issData;
  logic [7:0] r_dropCnt;

  // Reset synchroniser: assertion is immediate, release is retimed to clk.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_rstSync <= '0;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  // Grant selection in IDLE: a lone requester wins, on contention the one not granted last.
  always_comb begin
    w_grantA = 1'b0;
    w_grantB = 1'b0;
    if (r_state == ST_IDLE) begin
      if (iReqA && (!iReqB || !r_favB)) begin
        w_grantA = 1'b1;
      end else if (iReqB) begin
        w_grantB = 1'b1;
      end
    end
  end

  assign w_selAddr = w_grantB ? iAddrB : iAddrA;
  assign w_selData = w_grantB ? iDataB : iDataA;
  assign w_inRange = (w_selAddr <= ADDR_MAX);

  // Next-state and write-strobe decode.
  always_comb begin
    w_stateNxt = r_state;
    w_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_grantA || w_grantB) && w_inRange) begin
          w_stateNxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (clkEn) begin
          w_stateNxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Write is held back while clkEn is high, so a continuously asserted
        // enable stalls here rather than colliding with the voice update.
        if (!clkEn) begin
          w_we       = 1'b1;
          w_stateNxt = ST_IDLE;
        end
      end
      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // Accept pulses, latched request and round-robin pointer.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_ackA <= 1'b0;
      r_ackB <= 1'b0;
      r_favB <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_ackA <= w_grantA;
      r_ackB <= w_grantB;
      if (w_grantA || w_grantB) begin
        r_addr <= w_selAddr;
        r_data <= w_selData;
        r_favB <= w_grantA;
      end
    end
  end

  // Saturating count of accepted writes whose address was out of range.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_dropCnt <= '0;
    end else if ((w_grantA || w_grantB) && !w_inRange && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  // Last issued address/data, shown on the bus while no write is in flight.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_issAddr <= '0;
      r_issData <= '0;
    end else if (w_we) begin
      r_issAddr <= r_addr;
      r_issData <= r_data;
    end
  end

  assign oAckA    = r_ackA;
  assign oAckB    = r_ackB;
  assign oWE      = w_we;
  assign oAddr    = w_we ? r_addr : r_issAddr;
  assign oData    = w_we ? r_data : r_issData;
  assign oBusy    = (r_state != ST_IDLE);
  assign oDropCnt = r_dropCnt;

`ifdef SID_WRITE_SHADOW_EN
  localparam int unsigned DEPTH = int'(ADDR_MAX) + 1;

  logic [7:0] r_shadow [DEPTH];

  // Shadow register file, updated on every issued write.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_shadow <= '{default: '0};
    end else if (w_we) begin
      r_shadow[r_addr] <= r_data;
    end
  end

  assign oRdData = (iRdAddr <= ADDR_MAX) ? r_shadow[iRdAddr] : 8'h00;
`else
  logic w_unused_rdaddr;

  assign w_unused_rdaddr = ^iRdAddr;
  assign oRdData         = 8'h00;
`endif

endmodule

// File: tb/tb_sid_write_arb.sv
// Self-checking bench for sid_write_arb: scoreboard of expected bus writes plus
// per-scenario tasks for reset, latency, arbitration, drops and clkEn spacing.
module tb_sid_write_arb;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       iRstN = 1'b1;
  logic       clkEn = 1'b0;
  logic       iReqA = 1'b0;
  logic [4:0] iAddrA = '0;
  logic [7:0] iDataA = '0;
  logic       iReqB = 1'b0;
  logic [4:0] iAddrB = '0;
  logic [7:0] iDataB = '0;
  logic       oAckA;
  logic       oAckB;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oData;
  logic       oBusy;
  logic [7:0] oDropCnt;
  logic [4:0] iRdAddr = '0;
  logic [7:0] oRdData;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  int          en_mode  = 0;
  int unsigned en_cnt   = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;

  sid_write_arb #(.ADDR_MAX(5'h18)) dut (
    .clk      (clk),
    .iRstN    (iRstN),
    .clkEn    (clkEn),
    .iReqA    (iReqA),
    .iAddrA   (iAddrA),
    .iDataA   (iDataA),
    .iReqB    (iReqB),
    .iAddrB   (iAddrB),
    .iDataB   (iDataB),
    .oAckA    (oAckA),
    .oAckB    (oAckB),
    .oWE      (oWE),
    .oAddr    (oAddr),
    .oData    (oData),
    .oBusy    (oBusy),
    .oDropCnt (oDropCnt),
    .iRdAddr  (iRdAddr),
    .oRdData  (oRdData)
  );

  always #5 clk = ~clk;

  // clkEn source: 0 = off, 1 = one-cycle strobe every 16 clocks, 2 = held high.
  always @(posedge clk) begin
    #1;
    case (en_mode)
      1: begin
        en_cnt++;
        clkEn = ((en_cnt % 16) == 0);
      end
      2: clkEn = 1'b1;
      default: clkEn = 1'b0;
    endcase
  end

  // Write monitor: every oWE pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (oWE === 1'b1) begin
      n_writes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, want no write", oAddr, oData);
      end else begin
        mon_e = exp_q.pop_front();
        if (oAddr !== mon_e.a || oData !== mon_e.d) begin
          n_fail++;
          $display("FAIL write_value: got %h/%h, want %h/%h", oAddr, oData, mon_e.a, mon_e.d);
        end
      end
      n_tests++;
      if (clkEn !== 1'b0) begin
        n_fail++;
        $display("FAIL we_with_clken: got clkEn=%b during oWE, want 0", clkEn);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  function automatic wr_t mk(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic apply_reset();
    iRstN = 1'b0;
    iReqA = 1'b0;
    iReqB = 1'b0;
    en_mode = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    iRstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drive a request, wait for its accept pulse and drop it on the same cycle.
  task automatic drive_req(input bit sideB, input logic [4:0] a, input logic [7:0] d,
                           output int cyc);
    @(posedge clk);
    #1;
    if (sideB) begin
      iReqB = 1'b1; iAddrB = a; iDataB = d;
    end else begin
      iReqA = 1'b1; iAddrA = a; iDataA = d;
    end
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((sideB ? oAckB : oAckA) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (sideB) iReqB = 1'b0;
    else       iReqA = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    iRstN = 1'b0;
    #3;
    n_tests++;
    if ({oWE, oAckA, oAckB, oBusy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got we/ackA/ackB/busy=%b%b%b%b, want 0000", oWE, oAckA, oAckB, oBusy);
    end
    n_tests++;
    if (oAddr !== 5'h00 || oData !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h, want 00/00", oAddr, oData);
    end
    n_tests++;
    if (oDropCnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_drop: got %h, want 00", oDropCnt);
    end
    n_tests++;
    if (oRdData !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd: got %h, want 00", oRdData);
    end
    apply_reset();
    n_tests++;
    if (oBusy !== 1'b0 || oWE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b we=%b, want 0 0", oBusy, oWE);
    end
  endtask

  task automatic test_single_write();
    int cyc;
    bit en_last;
    bit found;
    en_mode = 1;
    exp_q.push_back(mk(5'h01, 8'h3C));
    drive_req(1'b0, 5'h01, 8'h3C, cyc);
    n_tests++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL single_ack_latency: got %0d, want 2", cyc);
    end
    n_tests++;
    if (oAckB !== 1'b0 || oBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack_state: got ackB=%b busy=%b, want 0 1", oAckB, oBusy);
    end
    en_last = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (oWE === 1'b1) begin
        found = 1'b1;
        break;
      end
      en_last = clkEn;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL single_write_seen: got none, want one oWE");
    end
    n_tests++;
    if (en_last !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_clken: got prev clkEn=%b, want 1", en_last);
    end
    @(negedge clk);
    n_tests++;
    if (oWE !== 1'b0 || oAddr !== 5'h01 || oData !== 8'h3C || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got we=%b %h/%h busy=%b, want 0 01/3c 0", oWE, oAddr, oData, oBusy);
    end
  endtask

  task automatic test_arbitration();
    int k;
    bit ok;
    apply_reset();
    en_mode = 1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(5'h02, 8'hA1));
      exp_q.push_back(mk(5'h03, 8'hB2));
    end
    @(posedge clk);
    #1;
    iReqA = 1'b1; iAddrA = 5'h02; iDataA = 8'hA1;
    iReqB = 1'b1; iAddrB = 5'h03; iDataB = 8'hB2;
    k = 0;
    for (int i = 0; i < 400 && k < 4; i++) begin
      @(negedge clk);
      if (oAckA === 1'b1 || oAckB === 1'b1) begin
        n_tests++;
        if (oAckA !== (k % 2 == 0) || oAckB !== (k % 2 == 1)) begin
          n_fail++;
          $display("FAIL arb_order%0d: got ackA=%b ackB=%b, want %s", k, oAckA, oAckB,
                   (k % 2 == 0) ? "A" : "B");
        end
        k++;
      end
    end
    iReqA = 1'b0;
    iReqB = 1'b0;
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL arb_grants: got %0d, want 4", k);
    end
    wait_drain(200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL arb_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_drop();
    int cyc;
    int k;
    int w0;
    int want;
    apply_reset();
    en_mode = 1;
    w0 = n_writes;
    drive_req(1'b1, 5'h1D, 8'h55, cyc);
    n_tests++;
    if (cyc != 2 || oAckA !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ack: got cyc=%0d ackA=%b, want 2 0", cyc, oAckA);
    end
    n_tests++;
    if (oDropCnt !== 8'h01 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_first: got cnt=%h busy=%b, want 01 0", oDropCnt, oBusy);
    end
    drive_req(1'b1, 5'h19, 8'h66, cyc);
    n_tests++;
    if (oDropCnt !== 8'h02) begin
      n_fail++;
      $display("FAIL drop_boundary: got %h, want 02", oDropCnt);
    end
    @(posedge clk);
    #1;
    iReqB = 1'b1; iAddrB = 5'h1D; iDataB = 8'h77;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oAckB === 1'b1) begin
        k++;
        want = (2 + k > 255) ? 255 : 2 + k;
        n_tests++;
        if (oDropCnt !== want[7:0]) begin
          n_fail++;
          $display("FAIL drop_count%0d: got %h, want %h", k, oDropCnt, want[7:0]);
        end
        if (k == 300) break;
      end
    end
    iReqB = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (k != 300 || oDropCnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_saturate: got acks=%0d cnt=%h, want 300 ff", k, oDropCnt);
    end
    n_tests++;
    if (n_writes != w0) begin
      n_fail++;
      $display("FAIL drop_no_write: got %0d writes, want 0", n_writes - w0);
    end
  endtask

  task automatic test_reset_wait();
    int cyc;
    int w0;
    en_mode = 0;
    w0 = n_writes;
    drive_req(1'b0, 5'h04, 8'h41, cyc);
    n_tests++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL rstwait_ack: got %0d, want 2", cyc);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (oBusy !== 1'b1 || oWE !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_pending: got busy=%b we=%b, want 1 0", oBusy, oWE);
    end
    #2;
    iRstN = 1'b0;
    #1;
    n_tests++;
    if ({oWE, oAckA, oAckB, oBusy} !== 4'b0000 || oAddr !== 5'h00 || oData !== 8'h00) begin
      n_fail++;
      $display("FAIL rstwait_async: got we/ack/busy=%b%b%b%b bus=%h/%h, want 0000 00/00",
               oWE, oAckA, oAckB, oBusy, oAddr, oData);
    end
    n_tests++;
    if (oDropCnt !== 8'h00) begin
      n_fail++;
      $display("FAIL rstwait_dropcnt: got %h, want 00", oDropCnt);
    end
    @(posedge clk);
    @(negedge clk);
    iRstN = 1'b1;
    en_mode = 1;
    repeat (40) @(negedge clk);
    n_tests++;
    if (n_writes != w0 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_discard: got writes=%0d busy=%b, want 0 0", n_writes - w0, oBusy);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int w0;
    bit en_seen;
    bit done;
    en_mode = 2;
    w0 = n_writes;
    acks = 0;
    en_seen = 1'b0;
    done = 1'b0;
    @(posedge clk);
    #1;
    iReqA = 1'b1; iAddrA = 5'h05; iDataA = 8'h50;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      if (clkEn === 1'b1) begin
        n_tests++;
        if (oWE !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_we_clken: got oWE=%b with clkEn high, want 0", oWE);
        end
      end
      if (oWE === 1'b1) begin
        n_tests++;
        if (!en_seen) begin
          n_fail++;
          $display("FAIL stream_rate: got two writes in one clkEn period, want one");
        end
        en_seen = 1'b0;
      end
      if (clkEn === 1'b1) en_seen = 1'b1;
      if (oAckA === 1'b1) begin
        exp_q.push_back(mk(iAddrA, iDataA));
        acks++;
        if (acks == 4) iReqA = 1'b0;
        else           iDataA = iDataA + 8'd1;
      end
      if (cyc == 30) begin
        n_tests++;
        if (acks != 1 || oBusy !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_holdoff: got acks=%0d busy=%b, want 1 1", acks, oBusy);
        end
        en_mode = 1;
      end
      if (acks == 4 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    iReqA = 1'b0;
    n_tests++;
    if (!done || n_writes - w0 != 4) begin
      n_fail++;
      $display("FAIL stream_done: got acks=%0d writes=%0d, want 4 4", acks, n_writes - w0);
    end
  endtask

  task automatic test_shadow();
    int cyc;
    bit ok;
    logic [7:0] want;
    en_mode = 1;
    exp_q.push_back(mk(5'h18, 8'h0F));
    drive_req(1'b0, 5'h18, 8'h0F, cyc);
    n_tests++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL shadow_ack: got %0d, want 2", cyc);
    end
    wait_drain(64, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL shadow_write: got %0d pending, want 0", exp_q.size());
    end
`ifdef SID_WRITE_SHADOW_EN
    want = 8'h0F;
`else
    want = 8'h00;
`endif
    iRdAddr = 5'h18;
    #1;
    n_tests++;
    if (oRdData !== want) begin
      n_fail++;
      $display("FAIL shadow_rd18: got %h, want %h", oRdData, want);
    end
    iRdAddr = 5'h1F;
    #1;
    n_tests++;
    if (oRdData !== 8'h00) begin
      n_fail++;
      $display("FAIL shadow_rd1f: got %h, want 00", oRdData);
    end
    iRdAddr = 5'h01;
    #1;
    n_tests++;
    if (oRdData !== 8'h00) begin
      n_fail++;
      $display("FAIL shadow_rd01: got %h, want 00", oRdData);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_drop();
    test_reset_wait();
    test_back_to_back();
    test_shadow();
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
